// File: rtl/nios_system_oci_trace_monitor_if.sv
// Valid/ready drain stream carrying captured trace entries {dct_count, dct_buffer}.
// The monitor drives it as master; the trace consumer attaches as slave.
interface nios_system_oci_trace_monitor_if #(
  parameter int BUF_W = 30,
  parameter int CNT_W = 4
);
  logic                   out_valid;
  logic                   out_ready;
  logic [CNT_W+BUF_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/nios_system_oci_trace_monitor.sv
// OCI debug-trace capture: first-word fall-through FIFO of {dct_count, dct_buffer} with
// saturating overflow counter, drained over valid/ready and sequenced IDLE/RUN/DRAIN/DONE.
module nios_system_oci_trace_monitor #(
  parameter int BUF_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                clear,
  input  logic                dct_valid,
  input  logic [BUF_W-1:0]    dct_buffer,
  input  logic [CNT_W-1:0]    dct_count,
  input  logic                test_ending,
  input  logic                test_has_ended,
  nios_system_oci_trace_monitor_if.master drain,
  output logic [ADDR_W:0]     fifo_level,
  output logic [OVF_W-1:0]    overflow_count,
  output logic                test_done,
  output logic [1:0]          state_o
);

  localparam int DATA_W = CNT_W + BUF_W;
  localparam int LVL_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W-1:0]   rd_ptr_r;
  logic [ADDR_W-1:0]   wr_ptr_nxt_s;
  logic [ADDR_W-1:0]   rd_ptr_nxt_s;
  logic [LVL_W-1:0]    level_r;
  logic [LVL_W-1:0]    level_nxt_s;
  logic [OVF_W-1:0]    ovf_r;
  logic                done_r;
  logic                valid_r;
  logic                valid_nxt_s;
  logic                active_s;
  logic                push_req_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                ovf_inc_s;
  logic                flush_s;

  // Handshake decode, next state and next FIFO bookkeeping.
  always_comb begin
    active_s    = (state_r == RUN) || (state_r == DRAIN);
    push_req_s  = dct_valid && (state_r == RUN) && (dct_count != {CNT_W{1'b0}});
    pop_s       = valid_r && drain.out_ready;
    full_s      = (level_r == LVL_W'(DEPTH));
    push_s      = push_req_s && (!full_s || pop_s);
    ovf_inc_s   = push_req_s && full_s && !pop_s;
    // Forced end discards whatever is still queued.
    flush_s     = test_has_ended && active_s;
    state_nxt_s = state_r;

    case (state_r)
      IDLE: begin
        if (arm) state_nxt_s = RUN;
        else     state_nxt_s = IDLE;
      end
      RUN: begin
        if (test_has_ended)   state_nxt_s = DONE;
        else if (test_ending) state_nxt_s = DRAIN;
        else                  state_nxt_s = RUN;
      end
      DRAIN: begin
        if (test_has_ended)                                          state_nxt_s = DONE;
        else if ((level_r == LVL_W'(0)) || ((level_r == LVL_W'(1)) && pop_s)) state_nxt_s = DONE;
        else                                                         state_nxt_s = DRAIN;
      end
      DONE:    state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase

    if (flush_s) begin
      wr_ptr_nxt_s = {ADDR_W{1'b0}};
      rd_ptr_nxt_s = {ADDR_W{1'b0}};
      level_nxt_s  = {LVL_W{1'b0}};
    end else begin
      wr_ptr_nxt_s = push_s ? wr_ptr_r + ADDR_W'(1) : wr_ptr_r;
      rd_ptr_nxt_s = pop_s  ? rd_ptr_r + ADDR_W'(1) : rd_ptr_r;
      if (push_s && !pop_s)      level_nxt_s = level_r + LVL_W'(1);
      else if (pop_s && !push_s) level_nxt_s = level_r - LVL_W'(1);
      else                       level_nxt_s = level_r;
    end

    valid_nxt_s = (level_nxt_s != {LVL_W{1'b0}}) &&
                  ((state_nxt_s == RUN) || (state_nxt_s == DRAIN));
  end

  // Control state, pointers, occupancy and overflow counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      ovf_r    <= {OVF_W{1'b0}};
      done_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else if (clear) begin
      state_r  <= IDLE;
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
      ovf_r    <= {OVF_W{1'b0}};
      done_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      done_r   <= (state_nxt_s == DONE);
      valid_r  <= valid_nxt_s;
      if (ovf_inc_s && (ovf_r != {OVF_W{1'b1}})) ovf_r <= ovf_r + OVF_W'(1);
      else                                       ovf_r <= ovf_r;
    end
  end

  // Storage array; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push_s && !clear) mem_r[wr_ptr_r] <= {dct_count, dct_buffer};
    else                  mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
  end

  assign drain.out_valid = valid_r;
  assign drain.out_data  = valid_r ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign fifo_level      = level_r;
  assign overflow_count  = ovf_r;
  assign test_done       = done_r;
  assign state_o         = state_r;

endmodule

// File: tb/tb_nios_system_oci_trace_monitor.sv
// Directed bench for the trace monitor: inputs change and outputs are sampled on the
// falling edge, expected values are hand-derived per scenario.
module tb_nios_system_oci_trace_monitor;

  logic        clk;
  logic        reset_n;
  logic        arm;
  logic        clear;
  logic        dct_valid;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_count;
  logic        test_done;
  logic [1:0]  state_o;
  int          tests_run;
  int          tests_failed;

  nios_system_oci_trace_monitor_if #(.BUF_W(30), .CNT_W(4)) drain_if ();

  nios_system_oci_trace_monitor #(
    .BUF_W(30), .CNT_W(4), .DEPTH(16), .ADDR_W(4), .OVF_W(16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .arm            (arm),
    .clear          (clear),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .drain          (drain_if.master),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count),
    .test_done      (test_done),
    .state_o        (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_clear();
    arm = 1'b0; dct_valid = 1'b0; drain_if.out_ready = 1'b0;
    test_ending = 1'b0; test_has_ended = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    tests_run++; if (state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    tests_run++; if (drain_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", drain_if.out_valid); end
    tests_run++; if (drain_if.out_data !== 34'd0) begin tests_failed++; $display("FAIL reset_data: got %0h expected 0", drain_if.out_data); end
    tests_run++; if ({overflow_count, test_done} !== 17'd0) begin tests_failed++; $display("FAIL reset_ovf_done: got %0h expected 0", {overflow_count, test_done}); end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    arm = 1'b1;
    tick(1);
    tests_run++; if (state_o !== 2'd1) begin tests_failed++; $display("FAIL basic_run: got %0d expected 1", state_o); end
    dct_valid = 1'b1; dct_count = 4'd5;
    for (int i = 0; i < 3; i++) begin
      dct_buffer = 30'(32'h0A1 + i);
      tick(1);
    end
    dct_valid = 1'b0;
    tests_run++; if (fifo_level !== 5'd3) begin tests_failed++; $display("FAIL basic_level3: got %0d expected 3", fifo_level); end
    tests_run++; if (drain_if.out_data !== {4'd5, 30'h0A1}) begin tests_failed++; $display("FAIL basic_head: got %0h expected %0h", drain_if.out_data, {4'd5, 30'h0A1}); end
    drain_if.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (drain_if.out_valid !== 1'b1 || drain_if.out_data !== {4'd5, 30'(32'h0A1 + i)}) begin
        tests_failed++; $display("FAIL basic_pop%0d: got v=%0b d=%0h expected v=1 d=%0h", i, drain_if.out_valid, drain_if.out_data, {4'd5, 30'(32'h0A1 + i)});
      end
      tick(1);
    end
    tests_run++; if (fifo_level !== 5'd0 || drain_if.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_empty: got level=%0d v=%0b expected 0/0", fifo_level, drain_if.out_valid); end
  endtask

  task automatic test_push_on_empty();
    drain_if.out_ready = 1'b1; dct_valid = 1'b1; dct_count = 4'd9; dct_buffer = 30'h0BEEF;
    tick(1);
    dct_valid = 1'b0;
    tests_run++; if (fifo_level !== 5'd1 || drain_if.out_data !== {4'd9, 30'h0BEEF}) begin tests_failed++; $display("FAIL empty_push: got level=%0d d=%0h expected 1/%0h", fifo_level, drain_if.out_data, {4'd9, 30'h0BEEF}); end
    tick(1);
    tests_run++; if (fifo_level !== 5'd0) begin tests_failed++; $display("FAIL empty_pop: got %0d expected 0", fifo_level); end
    drain_if.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    dct_valid = 1'b1; dct_count = 4'd3;
    for (int i = 0; i < 20; i++) begin
      dct_buffer = 30'(100 + i);
      tick(1);
    end
    tests_run++; if (fifo_level !== 5'd16) begin tests_failed++; $display("FAIL ovf_level: got %0d expected 16", fifo_level); end
    tests_run++; if (overflow_count !== 16'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d expected 4", overflow_count); end
    drain_if.out_ready = 1'b1; dct_buffer = 30'd120;
    tick(1);
    dct_valid = 1'b0; drain_if.out_ready = 1'b0;
    tests_run++; if (fifo_level !== 5'd16 || overflow_count !== 16'd4) begin tests_failed++; $display("FAIL full_pushpop: got level=%0d ovf=%0d expected 16/4", fifo_level, overflow_count); end
    tests_run++; if (drain_if.out_data !== {4'd3, 30'd101}) begin tests_failed++; $display("FAIL full_head: got %0h expected %0h", drain_if.out_data, {4'd3, 30'd101}); end
    do_clear();
    tests_run++; if (state_o !== 2'd0 || fifo_level !== 5'd0 || overflow_count !== 16'd0) begin tests_failed++; $display("FAIL clear1: got st=%0d lvl=%0d ovf=%0d expected 0/0/0", state_o, fifo_level, overflow_count); end
  endtask

  task automatic test_drain();
    arm = 1'b1;
    tick(1);
    dct_valid = 1'b1; dct_count = 4'd2;
    for (int i = 0; i < 5; i++) begin
      dct_buffer = 30'(200 + i);
      test_ending = (i == 4);
      tick(1);
    end
    test_ending = 1'b0;
    tests_run++; if (state_o !== 2'd2 || fifo_level !== 5'd5) begin tests_failed++; $display("FAIL drain_enter: got st=%0d lvl=%0d expected 2/5", state_o, fifo_level); end
    tick(3);
    tests_run++; if (fifo_level !== 5'd5 || overflow_count !== 16'd0 || drain_if.out_valid !== 1'b1) begin tests_failed++; $display("FAIL drain_block: got lvl=%0d ovf=%0d v=%0b expected 5/0/1", fifo_level, overflow_count, drain_if.out_valid); end
    drain_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (drain_if.out_data !== {4'd2, 30'(200 + i)}) begin
        tests_failed++; $display("FAIL drain_pop%0d: got %0h expected %0h", i, drain_if.out_data, {4'd2, 30'(200 + i)});
      end
      tick(1);
    end
    tests_run++; if (state_o !== 2'd3 || test_done !== 1'b1 || fifo_level !== 5'd0) begin tests_failed++; $display("FAIL drain_done: got st=%0d done=%0b lvl=%0d expected 3/1/0", state_o, test_done, fifo_level); end
    do_clear();
  endtask

  task automatic test_has_ended_flush();
    arm = 1'b1;
    tick(1);
    dct_valid = 1'b1; dct_count = 4'd7;
    for (int i = 0; i < 8; i++) begin
      dct_buffer = 30'(300 + i);
      tick(1);
    end
    dct_valid = 1'b0;
    tests_run++; if (fifo_level !== 5'd8) begin tests_failed++; $display("FAIL flush_pre: got %0d expected 8", fifo_level); end
    test_ending = 1'b1; test_has_ended = 1'b1;
    tick(1);
    test_ending = 1'b0; test_has_ended = 1'b0;
    tests_run++; if (state_o !== 2'd3 || fifo_level !== 5'd0 || drain_if.out_valid !== 1'b0 || test_done !== 1'b1) begin tests_failed++; $display("FAIL flush_done: got st=%0d lvl=%0d v=%0b done=%0b expected 3/0/0/1", state_o, fifo_level, drain_if.out_valid, test_done); end
    tick(3);
    tests_run++; if (state_o !== 2'd3) begin tests_failed++; $display("FAIL done_sticky: got %0d expected 3", state_o); end
    do_clear();
    tests_run++; if (state_o !== 2'd0 || test_done !== 1'b0 || overflow_count !== 16'd0) begin tests_failed++; $display("FAIL clear2: got st=%0d done=%0b ovf=%0d expected 0/0/0", state_o, test_done, overflow_count); end
  endtask

  task automatic test_zero_and_saturate();
    arm = 1'b1;
    tick(1);
    dct_valid = 1'b1; dct_count = 4'd0; dct_buffer = 30'h3;
    tick(3);
    tests_run++; if (fifo_level !== 5'd0 || overflow_count !== 16'd0) begin tests_failed++; $display("FAIL zero_count: got lvl=%0d ovf=%0d expected 0/0", fifo_level, overflow_count); end
    dct_count = 4'd1;
    tick(16 + 65534);
    tests_run++; if (overflow_count !== 16'hFFFE || fifo_level !== 5'd16) begin tests_failed++; $display("FAIL sat_pre: got ovf=%0h lvl=%0d expected fffe/16", overflow_count, fifo_level); end
    tick(10);
    tests_run++; if (overflow_count !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold: got %0h expected ffff", overflow_count); end
    do_clear();
  endtask

  task automatic test_async_reset();
    arm = 1'b1;
    tick(1);
    dct_valid = 1'b1; dct_count = 4'd4;
    for (int i = 0; i < 4; i++) begin
      dct_buffer = 30'(400 + i);
      test_ending = (i == 3);
      tick(1);
    end
    dct_valid = 1'b0; test_ending = 1'b0; arm = 1'b0;
    tests_run++; if (state_o !== 2'd2 || fifo_level !== 5'd4) begin tests_failed++; $display("FAIL areset_pre: got st=%0d lvl=%0d expected 2/4", state_o, fifo_level); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (state_o !== 2'd0 || fifo_level !== 5'd0 || drain_if.out_valid !== 1'b0 || drain_if.out_data !== 34'd0 || test_done !== 1'b0 || overflow_count !== 16'd0) begin
      tests_failed++; $display("FAIL areset: got st=%0d lvl=%0d v=%0b d=%0h done=%0b ovf=%0d expected all 0", state_o, fifo_level, drain_if.out_valid, drain_if.out_data, test_done, overflow_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    tests_run++; if (state_o !== 2'd0 || fifo_level !== 5'd0) begin tests_failed++; $display("FAIL areset_after: got st=%0d lvl=%0d expected 0/0", state_o, fifo_level); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0; arm = 1'b0; clear = 1'b0; dct_valid = 1'b0;
    dct_buffer = 30'd0; dct_count = 4'd0; test_ending = 1'b0; test_has_ended = 1'b0;
    drain_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_push_on_empty();
    test_overflow();
    test_drain();
    test_has_ended_flush();
    test_zero_and_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
